// File: rtl/tilelink_n_to_1_arbiter.sv
// TileLink-UL/UH N-to-1 arbiter.
// A channel: round-robin grant with burst locking, then one registered slice.
// The winning master index is prepended to a_source so that D responses can
// be steered back to their owner by stripping that tag combinationally.
//
// Handshake rule on every channel: a beat transfers on a clock edge where
// valid and ready are both high; valid never waits on ready, and once a
// registered output is valid its payload holds until ready is seen.
module tilelink_n_to_1_arbiter #(
  parameter int N     = 2,
  parameter int TL_DW = 32,
  parameter int TL_AW = 32,
  parameter int TL_RS = 4,
  parameter int TL_SZ = 4
) (
  input  logic                           tilelink_clock_i,
  input  logic                           tilelink_reset_i,
  // Master-side A channel
  input  logic [3*N-1:0]                 master_a_opcode,
  input  logic [3*N-1:0]                 master_a_param,
  input  logic [TL_SZ*N-1:0]             master_a_size,
  input  logic [TL_RS*N-1:0]             master_a_source,
  input  logic [TL_AW*N-1:0]             master_a_address,
  input  logic [(TL_DW/8)*N-1:0]         master_a_mask,
  input  logic [TL_DW*N-1:0]             master_a_data,
  input  logic [N-1:0]                   master_a_corrupt,
  input  logic [N-1:0]                   master_a_valid,
  output logic [N-1:0]                   master_a_ready,
  // Master-side D channel
  output logic [3*N-1:0]                 master_d_opcode,
  output logic [2*N-1:0]                 master_d_param,
  output logic [TL_SZ*N-1:0]             master_d_size,
  output logic [TL_RS*N-1:0]             master_d_source,
  output logic [N-1:0]                   master_d_denied,
  output logic [TL_DW*N-1:0]             master_d_data,
  output logic [N-1:0]                   master_d_corrupt,
  output logic [N-1:0]                   master_d_valid,
  input  logic [N-1:0]                   master_d_ready,
  // Slave-side A channel (registered)
  output logic [2:0]                     slave_a_opcode,
  output logic [2:0]                     slave_a_param,
  output logic [TL_SZ-1:0]               slave_a_size,
  output logic [TL_RS+$clog2(N)-1:0]     slave_a_source,
  output logic [TL_AW-1:0]               slave_a_address,
  output logic [TL_DW/8-1:0]             slave_a_mask,
  output logic [TL_DW-1:0]               slave_a_data,
  output logic                           slave_a_corrupt,
  output logic                           slave_a_valid,
  input  logic                           slave_a_ready,
  // Slave-side D channel
  input  logic [2:0]                     slave_d_opcode,
  input  logic [1:0]                     slave_d_param,
  input  logic [TL_SZ-1:0]               slave_d_size,
  input  logic [TL_RS+$clog2(N)-1:0]     slave_d_source,
  input  logic                           slave_d_denied,
  input  logic [TL_DW-1:0]               slave_d_data,
  input  logic                           slave_d_corrupt,
  input  logic                           slave_d_valid,
  output logic                           slave_d_ready,
  // Debug view of the arbitration state
  output logic                           dbg_lock_o,
  output logic [$clog2(N)-1:0]           dbg_lock_idx_o,
  output logic [$clog2(N)-1:0]           dbg_rr_ptr_o,
  output logic [12:0]                    dbg_beat_cnt_o
);

  localparam int IW = $clog2(N);
  localparam int MW = TL_DW / 8;
  localparam int B  = $clog2(MW);
  localparam int CW = 13;

  typedef logic [IW-1:0] idx_t;
  typedef enum logic { S_IDLE = 1'b0, S_BURST = 1'b1 } state_t;

  state_t          state_q;
  idx_t            lock_idx_q;
  idx_t            rr_q;
  logic [CW-1:0]   cnt_q;
  logic            a_valid_q;

  logic [2:0]       a_opcode_q;
  logic [2:0]       a_param_q;
  logic [TL_SZ-1:0] a_size_q;
  logic [TL_RS+IW-1:0] a_source_q;
  logic [TL_AW-1:0] a_address_q;
  logic [MW-1:0]    a_mask_q;
  logic [TL_DW-1:0] a_data_q;
  logic             a_corrupt_q;

  logic             advance;
  logic             gnt_found;
  idx_t             gnt_idx;
  logic             accept;
  int               scan_c;

  logic [2:0]       sel_opcode;
  logic [2:0]       sel_param;
  logic [TL_SZ-1:0] sel_size;
  logic [TL_RS-1:0] sel_source;
  logic [TL_AW-1:0] sel_address;
  logic [MW-1:0]    sel_mask;
  logic [TL_DW-1:0] sel_data;
  logic             sel_corrupt;

  logic             sel_multi;
  logic [CW-1:0]    sel_len_m1;

  idx_t             d_idx;

  // Wrap an index to the next master, modulo N.
  function automatic idx_t inc_idx(input idx_t v);
    if (v == idx_t'(N - 1)) return '0;
    return v + 1'b1;
  endfunction

  // The output slice can take a new beat when empty or draining this cycle.
  assign advance = !a_valid_q || slave_a_ready;

  // Grant: locked master only while in a burst, otherwise first valid from rr_q.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_c    = 0;
    if (state_q == S_BURST) begin
      gnt_found = master_a_valid[lock_idx_q];
      gnt_idx   = lock_idx_q;
    end else begin
      for (int k = 0; k < N; k++) begin
        scan_c = int'(rr_q) + k;
        if (scan_c >= N) scan_c = scan_c - N;
        if (!gnt_found && master_a_valid[idx_t'(scan_c)]) begin
          gnt_found = 1'b1;
          gnt_idx   = idx_t'(scan_c);
        end
      end
    end
  end

  assign accept = gnt_found && advance;

  // One-hot ready back to the winning master only.
  always_comb begin
    master_a_ready = '0;
    for (int i = 0; i < N; i++) begin
      master_a_ready[i] = accept && (gnt_idx == idx_t'(i));
    end
  end

  // Select the winning master's A payload.
  always_comb begin
    sel_opcode  = '0;
    sel_param   = '0;
    sel_size    = '0;
    sel_source  = '0;
    sel_address = '0;
    sel_mask    = '0;
    sel_data    = '0;
    sel_corrupt = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (gnt_idx == idx_t'(i)) begin
        sel_opcode  = master_a_opcode[i*3 +: 3];
        sel_param   = master_a_param[i*3 +: 3];
        sel_size    = master_a_size[i*TL_SZ +: TL_SZ];
        sel_source  = master_a_source[i*TL_RS +: TL_RS];
        sel_address = master_a_address[i*TL_AW +: TL_AW];
        sel_mask    = master_a_mask[i*MW +: MW];
        sel_data    = master_a_data[i*TL_DW +: TL_DW];
        sel_corrupt = master_a_corrupt[i];
      end
    end
  end

  // Only data-carrying opcodes (0..3) larger than one beat and at most 4 KiB burst.
  always_comb begin
    sel_multi  = !sel_opcode[2] && (int'(sel_size) > B) && (int'(sel_size) <= 12);
    sel_len_m1 = '0;
    if (sel_multi) begin
      sel_len_m1 = CW'((32'd1 << (int'(sel_size) - B)) - 32'd1);
    end
  end

  // Lock FSM, round-robin pointer, beat counter and output-slice valid.
  always_ff @(posedge tilelink_clock_i or posedge tilelink_reset_i) begin
    if (tilelink_reset_i) begin
      state_q    <= S_IDLE;
      lock_idx_q <= '0;
      rr_q       <= '0;
      cnt_q      <= '0;
      a_valid_q  <= 1'b0;
    end else begin
      if (advance) a_valid_q <= accept;
      if (accept) begin
        case (state_q)
          S_IDLE: begin
            if (sel_multi) begin
              state_q    <= S_BURST;
              lock_idx_q <= gnt_idx;
              cnt_q      <= sel_len_m1;
            end else begin
              rr_q <= inc_idx(gnt_idx);
            end
          end
          S_BURST: begin
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
              state_q <= S_IDLE;
              rr_q    <= inc_idx(gnt_idx);
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  // Output payload loads on accept and holds while the slave stalls.
  always_ff @(posedge tilelink_clock_i) begin
    if (accept) begin
      a_opcode_q  <= sel_opcode;
      a_param_q   <= sel_param;
      a_size_q    <= sel_size;
      a_source_q  <= {gnt_idx, sel_source};
      a_address_q <= sel_address;
      a_mask_q    <= sel_mask;
      a_data_q    <= sel_data;
      a_corrupt_q <= sel_corrupt;
    end
  end

  assign slave_a_opcode  = a_opcode_q;
  assign slave_a_param   = a_param_q;
  assign slave_a_size    = a_size_q;
  assign slave_a_source  = a_source_q;
  assign slave_a_address = a_address_q;
  assign slave_a_mask    = a_mask_q;
  assign slave_a_data    = a_data_q;
  assign slave_a_corrupt = a_corrupt_q;
  assign slave_a_valid   = a_valid_q;

  assign dbg_lock_o     = (state_q == S_BURST);
  assign dbg_lock_idx_o = lock_idx_q;
  assign dbg_rr_ptr_o   = rr_q;
  assign dbg_beat_cnt_o = cnt_q;

  assign d_idx = slave_d_source[TL_RS+IW-1:TL_RS];

  // D steering by tag; an out-of-range tag is sunk (ready high, no valid).
  always_comb begin
    master_d_valid = '0;
    slave_d_ready  = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (d_idx == idx_t'(i)) begin
        master_d_valid[i] = slave_d_valid;
        slave_d_ready     = master_d_ready[i];
      end
    end
  end

  assign master_d_opcode  = {N{slave_d_opcode}};
  assign master_d_param   = {N{slave_d_param}};
  assign master_d_size    = {N{slave_d_size}};
  assign master_d_source  = {N{slave_d_source[TL_RS-1:0]}};
  assign master_d_denied  = {N{slave_d_denied}};
  assign master_d_data    = {N{slave_d_data}};
  assign master_d_corrupt = {N{slave_d_corrupt}};

endmodule

// File: tb/tb_tilelink_n_to_1_arbiter.sv
// Directed bench for the 2-master TileLink arbiter.
module tb_tilelink_n_to_1_arbiter;

  localparam int N = 2;

  logic        clk;
  logic        rst;

  logic [3*N-1:0]  m_a_opcode;
  logic [3*N-1:0]  m_a_param;
  logic [4*N-1:0]  m_a_size;
  logic [4*N-1:0]  m_a_source;
  logic [32*N-1:0] m_a_address;
  logic [4*N-1:0]  m_a_mask;
  logic [32*N-1:0] m_a_data;
  logic [N-1:0]    m_a_corrupt;
  logic [N-1:0]    m_a_valid;
  logic [N-1:0]    m_a_ready;

  logic [3*N-1:0]  m_d_opcode;
  logic [2*N-1:0]  m_d_param;
  logic [4*N-1:0]  m_d_size;
  logic [4*N-1:0]  m_d_source;
  logic [N-1:0]    m_d_denied;
  logic [32*N-1:0] m_d_data;
  logic [N-1:0]    m_d_corrupt;
  logic [N-1:0]    m_d_valid;
  logic [N-1:0]    m_d_ready;

  logic [2:0]  s_a_opcode;
  logic [2:0]  s_a_param;
  logic [3:0]  s_a_size;
  logic [4:0]  s_a_source;
  logic [31:0] s_a_address;
  logic [3:0]  s_a_mask;
  logic [31:0] s_a_data;
  logic        s_a_corrupt;
  logic        s_a_valid;
  logic        s_a_ready;

  logic [2:0]  s_d_opcode;
  logic [1:0]  s_d_param;
  logic [3:0]  s_d_size;
  logic [4:0]  s_d_source;
  logic        s_d_denied;
  logic [31:0] s_d_data;
  logic        s_d_corrupt;
  logic        s_d_valid;
  logic        s_d_ready;

  logic        dbg_lock;
  logic [0:0]  dbg_lock_idx;
  logic [0:0]  dbg_rr;
  logic [12:0] dbg_cnt;

  int tests_run;
  int tests_failed;

  tilelink_n_to_1_arbiter #(.N(N), .TL_DW(32), .TL_AW(32), .TL_RS(4), .TL_SZ(4)) dut (
    .tilelink_clock_i (clk),
    .tilelink_reset_i (rst),
    .master_a_opcode  (m_a_opcode),
    .master_a_param   (m_a_param),
    .master_a_size    (m_a_size),
    .master_a_source  (m_a_source),
    .master_a_address (m_a_address),
    .master_a_mask    (m_a_mask),
    .master_a_data    (m_a_data),
    .master_a_corrupt (m_a_corrupt),
    .master_a_valid   (m_a_valid),
    .master_a_ready   (m_a_ready),
    .master_d_opcode  (m_d_opcode),
    .master_d_param   (m_d_param),
    .master_d_size    (m_d_size),
    .master_d_source  (m_d_source),
    .master_d_denied  (m_d_denied),
    .master_d_data    (m_d_data),
    .master_d_corrupt (m_d_corrupt),
    .master_d_valid   (m_d_valid),
    .master_d_ready   (m_d_ready),
    .slave_a_opcode   (s_a_opcode),
    .slave_a_param    (s_a_param),
    .slave_a_size     (s_a_size),
    .slave_a_source   (s_a_source),
    .slave_a_address  (s_a_address),
    .slave_a_mask     (s_a_mask),
    .slave_a_data     (s_a_data),
    .slave_a_corrupt  (s_a_corrupt),
    .slave_a_valid    (s_a_valid),
    .slave_a_ready    (s_a_ready),
    .slave_d_opcode   (s_d_opcode),
    .slave_d_param    (s_d_param),
    .slave_d_size     (s_d_size),
    .slave_d_source   (s_d_source),
    .slave_d_denied   (s_d_denied),
    .slave_d_data     (s_d_data),
    .slave_d_corrupt  (s_d_corrupt),
    .slave_d_valid    (s_d_valid),
    .slave_d_ready    (s_d_ready),
    .dbg_lock_o       (dbg_lock),
    .dbg_lock_idx_o   (dbg_lock_idx),
    .dbg_rr_ptr_o     (dbg_rr),
    .dbg_beat_cnt_o   (dbg_cnt)
  );

  // Clock and run-time guard
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks: inputs change only on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_master(input int idx, input logic [2:0] op, input logic [3:0] sz,
                            input logic [3:0] src, input logic [31:0] addr,
                            input logic [31:0] dat, input logic v);
    m_a_opcode[idx*3 +: 3]   = op;
    m_a_param[idx*3 +: 3]    = 3'd0;
    m_a_size[idx*4 +: 4]     = sz;
    m_a_source[idx*4 +: 4]   = src;
    m_a_address[idx*32 +: 32] = addr;
    m_a_mask[idx*4 +: 4]     = 4'hF;
    m_a_data[idx*32 +: 32]   = dat;
    m_a_corrupt[idx]         = 1'b0;
    m_a_valid[idx]           = v;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    tests_run++;
    if (s_a_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b want 0", s_a_valid); end
    tests_run++;
    if (dbg_lock !== 1'b0 || dbg_rr !== 1'b0 || dbg_cnt !== 13'd0 || dbg_lock_idx !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: lock %b idx %b rr %b cnt %0d want all 0", dbg_lock, dbg_lock_idx, dbg_rr, dbg_cnt);
    end
    rst = 1'b0;
    tick();
    tests_run++;
    if (s_a_valid !== 1'b0 || m_a_ready !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_idle: valid %b ready %b want 0 00", s_a_valid, m_a_ready);
    end
  endtask

  task automatic test_single_get();
    set_master(0, 3'd4, 4'd2, 4'd3, 32'h100, 32'h0, 1'b1);
    #1;
    tests_run++;
    if (m_a_ready !== 2'b01) begin tests_failed++; $display("FAIL get_ready: got %b want 01", m_a_ready); end
    tick();
    tests_run++;
    if (s_a_valid !== 1'b1 || s_a_source !== 5'h03 || s_a_opcode !== 3'd4 ||
        s_a_address !== 32'h100 || s_a_size !== 4'd2) begin
      tests_failed++;
      $display("FAIL get_slice: valid %b src %h op %0d addr %h size %0d want 1 03 4 100 2",
               s_a_valid, s_a_source, s_a_opcode, s_a_address, s_a_size);
    end
    tests_run++;
    if (dbg_rr !== 1'b1 || dbg_lock !== 1'b0) begin
      tests_failed++; $display("FAIL get_rr: rr %b lock %b want 1 0", dbg_rr, dbg_lock);
    end
    set_master(0, 3'd4, 4'd2, 4'd3, 32'h100, 32'h0, 1'b0);
    #1;
    tests_run++;
    if (m_a_ready !== 2'b00) begin tests_failed++; $display("FAIL get_ready_drop: got %b want 00", m_a_ready); end
    tick();
    tests_run++;
    if (s_a_valid !== 1'b0) begin tests_failed++; $display("FAIL get_drain: valid %b want 0", s_a_valid); end
  endtask

  task automatic test_rr_alternate();
    logic       exp_win;
    logic [3:0] exp_src;
    set_master(0, 3'd0, 4'd2, 4'hA, 32'h200, 32'hAAAA0000, 1'b1);
    set_master(1, 3'd0, 4'd2, 4'h6, 32'h300, 32'hBBBB0000, 1'b1);
    exp_win = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      tests_run++;
      if (m_a_ready !== (exp_win ? 2'b10 : 2'b01)) begin
        tests_failed++; $display("FAIL rr_ready[%0d]: got %b want winner %0d", c, m_a_ready, exp_win);
      end
      tick();
      exp_src = exp_win ? 4'h6 : 4'hA;
      tests_run++;
      if (s_a_valid !== 1'b1 || s_a_source !== {exp_win, exp_src} || dbg_rr !== ~exp_win) begin
        tests_failed++;
        $display("FAIL rr_beat[%0d]: valid %b src %h rr %b want 1 %h %b", c, s_a_valid, s_a_source,
                 dbg_rr, {exp_win, exp_src}, ~exp_win);
      end
      exp_win = ~exp_win;
    end
    m_a_valid = 2'b00;
    tick();
    tests_run++;
    if (s_a_valid !== 1'b0) begin tests_failed++; $display("FAIL rr_drain: valid %b want 0", s_a_valid); end
  endtask

  task automatic test_burst_lock();
    logic [12:0] exp_cnt [4];
    logic        exp_lock [4];
    exp_cnt  = '{13'd3, 13'd2, 13'd1, 13'd0};
    exp_lock = '{1'b1, 1'b1, 1'b1, 1'b0};
    set_master(0, 3'd0, 4'd2, 4'h1, 32'h400, 32'h11110000, 1'b0);
    for (int beat = 0; beat < 4; beat++) begin
      set_master(1, 3'd0, 4'd4, 4'h2, 32'h500, 32'hD0000000 + beat, 1'b1);
      if (beat == 1) m_a_valid[0] = 1'b1;
      #1;
      tests_run++;
      if (m_a_ready !== 2'b10) begin tests_failed++; $display("FAIL burst_ready[%0d]: got %b want 10", beat, m_a_ready); end
      tick();
      tests_run++;
      if (s_a_source !== 5'h12 || s_a_data !== (32'hD0000000 + beat) || s_a_valid !== 1'b1) begin
        tests_failed++;
        $display("FAIL burst_beat[%0d]: src %h data %h valid %b want 12 %h 1", beat, s_a_source,
                 s_a_data, s_a_valid, 32'hD0000000 + beat);
      end
      tests_run++;
      if (dbg_lock !== exp_lock[beat] || dbg_cnt !== exp_cnt[beat]) begin
        tests_failed++;
        $display("FAIL burst_lock[%0d]: lock %b cnt %0d want %b %0d", beat, dbg_lock, dbg_cnt,
                 exp_lock[beat], exp_cnt[beat]);
      end
    end
    tests_run++;
    if (dbg_rr !== 1'b0) begin tests_failed++; $display("FAIL burst_rr: rr %b want 0", dbg_rr); end
    m_a_valid[1] = 1'b0;
    #1;
    tests_run++;
    if (m_a_ready !== 2'b01) begin tests_failed++; $display("FAIL burst_after_ready: got %b want 01", m_a_ready); end
    tick();
    tests_run++;
    if (s_a_source !== 5'h01 || dbg_rr !== 1'b1) begin
      tests_failed++; $display("FAIL burst_after_beat: src %h rr %b want 01 1", s_a_source, dbg_rr);
    end
    m_a_valid = 2'b00;
    tick();
  endtask

  task automatic test_backpressure();
    set_master(0, 3'd0, 4'd2, 4'h7, 32'h600, 32'hCAFE0000, 1'b1);
    s_a_ready = 1'b1;
    tick();
    tests_run++;
    if (s_a_valid !== 1'b1 || s_a_data !== 32'hCAFE0000) begin
      tests_failed++; $display("FAIL bp_first: valid %b data %h want 1 cafe0000", s_a_valid, s_a_data);
    end
    set_master(0, 3'd0, 4'd2, 4'h8, 32'h604, 32'hBEEF0001, 1'b1);
    s_a_ready = 1'b0;
    #1;
    tests_run++;
    if (m_a_ready !== 2'b00) begin tests_failed++; $display("FAIL bp_ready: got %b want 00", m_a_ready); end
    for (int c = 0; c < 3; c++) begin
      tick();
      tests_run++;
      if (s_a_valid !== 1'b1 || s_a_data !== 32'hCAFE0000 || s_a_source !== 5'h07 ||
          s_a_address !== 32'h600 || m_a_ready !== 2'b00) begin
        tests_failed++;
        $display("FAIL bp_hold[%0d]: valid %b data %h src %h addr %h ready %b want 1 cafe0000 07 600 00",
                 c, s_a_valid, s_a_data, s_a_source, s_a_address, m_a_ready);
      end
    end
    s_a_ready = 1'b1;
    #1;
    tests_run++;
    if (m_a_ready !== 2'b01) begin tests_failed++; $display("FAIL bp_release_ready: got %b want 01", m_a_ready); end
    tick();
    tests_run++;
    if (s_a_valid !== 1'b1 || s_a_data !== 32'hBEEF0001 || s_a_source !== 5'h08) begin
      tests_failed++;
      $display("FAIL bp_release_beat: valid %b data %h src %h want 1 beef0001 08", s_a_valid, s_a_data, s_a_source);
    end
    m_a_valid = 2'b00;
    tick();
  endtask

  task automatic test_beat_rules();
    logic [2:0]  ops  [5];
    logic [3:0]  szs  [5];
    logic        lks  [5];
    logic [12:0] cnts [5];
    ops  = '{3'd4, 3'd0, 3'd1, 3'd1, 3'd2};
    szs  = '{4'd4, 4'd13, 4'd3, 4'd3, 4'd2};
    lks  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    cnts = '{13'd0, 13'd0, 13'd1, 13'd0, 13'd0};
    for (int v = 0; v < 5; v++) begin
      set_master(0, ops[v], szs[v], 4'h9, 32'h700, 32'h0 + v, 1'b1);
      #1;
      tests_run++;
      if (m_a_ready !== 2'b01) begin tests_failed++; $display("FAIL beats_ready[%0d]: got %b want 01", v, m_a_ready); end
      tick();
      tests_run++;
      if (dbg_lock !== lks[v] || dbg_cnt !== cnts[v]) begin
        tests_failed++;
        $display("FAIL beats_rule[%0d]: op %0d size %0d lock %b cnt %0d want %b %0d", v, ops[v], szs[v],
                 dbg_lock, dbg_cnt, lks[v], cnts[v]);
      end
    end
    m_a_valid = 2'b00;
    tick();
  endtask

  task automatic test_d_routing();
    s_d_opcode  = 3'd1;
    s_d_param   = 2'd0;
    s_d_size    = 4'd2;
    s_d_denied  = 1'b0;
    s_d_corrupt = 1'b0;
    s_d_data    = 32'h12345678;
    s_d_source  = 5'h15;
    s_d_valid   = 1'b1;
    m_d_ready   = 2'b00;
    #1;
    tests_run++;
    if (m_d_valid !== 2'b10 || m_d_source[7:4] !== 4'd5 || s_d_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL d_tag1: valid %b src %h ready %b want 10 5 0", m_d_valid, m_d_source[7:4], s_d_ready);
    end
    tests_run++;
    if (m_d_data[63:32] !== 32'h12345678 || m_d_data[31:0] !== 32'h12345678 || m_d_opcode[5:3] !== 3'd1) begin
      tests_failed++; $display("FAIL d_fanout: data %h op %0d want 12345678 1", m_d_data, m_d_opcode[5:3]);
    end
    m_d_ready = 2'b10;
    #1;
    tests_run++;
    if (s_d_ready !== 1'b1) begin tests_failed++; $display("FAIL d_ready1: got %b want 1", s_d_ready); end
    s_d_source = 5'h07;
    #1;
    tests_run++;
    if (m_d_valid !== 2'b01 || m_d_source[3:0] !== 4'd7 || s_d_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL d_tag0: valid %b src %h ready %b want 01 7 0", m_d_valid, m_d_source[3:0], s_d_ready);
    end
    m_d_ready = 2'b01;
    #1;
    tests_run++;
    if (s_d_ready !== 1'b1) begin tests_failed++; $display("FAIL d_ready0: got %b want 1", s_d_ready); end
    s_d_valid = 1'b0;
    #1;
    tests_run++;
    if (m_d_valid !== 2'b00) begin tests_failed++; $display("FAIL d_idle: valid %b want 00", m_d_valid); end
    m_d_ready = 2'b00;
    tick();
  endtask

  task automatic test_reset_mid_burst();
    set_master(1, 3'd0, 4'd4, 4'h3, 32'h800, 32'hE0000000, 1'b1);
    #1;
    tests_run++;
    if (m_a_ready !== 2'b10) begin tests_failed++; $display("FAIL rstb_ready: got %b want 10", m_a_ready); end
    tick();
    set_master(0, 3'd0, 4'd2, 4'h4, 32'h900, 32'hF0000000, 1'b1);
    tick();
    tests_run++;
    if (dbg_lock !== 1'b1 || dbg_cnt !== 13'd2 || s_a_source !== 5'h13) begin
      tests_failed++; $display("FAIL rstb_beat2: lock %b cnt %0d src %h want 1 2 13", dbg_lock, dbg_cnt, s_a_source);
    end
    rst = 1'b1;
    #1;
    tests_run++;
    if (s_a_valid !== 1'b0 || dbg_lock !== 1'b0 || dbg_cnt !== 13'd0 || dbg_rr !== 1'b0) begin
      tests_failed++;
      $display("FAIL rstb_async: valid %b lock %b cnt %0d rr %b want 0 0 0 0", s_a_valid, dbg_lock, dbg_cnt, dbg_rr);
    end
    m_a_valid[1] = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    tests_run++;
    if (m_a_ready !== 2'b01) begin tests_failed++; $display("FAIL rstb_regrant: got %b want 01", m_a_ready); end
    tick();
    tests_run++;
    if (s_a_valid !== 1'b1 || s_a_source !== 5'h04 || dbg_lock !== 1'b0) begin
      tests_failed++;
      $display("FAIL rstb_after: valid %b src %h lock %b want 1 04 0", s_a_valid, s_a_source, dbg_lock);
    end
    m_a_valid = 2'b00;
    tick();
  endtask

  // Test sequence and final report
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    m_a_opcode = '0; m_a_param = '0; m_a_size = '0; m_a_source = '0;
    m_a_address = '0; m_a_mask = '0; m_a_data = '0; m_a_corrupt = '0; m_a_valid = '0;
    m_d_ready = '0;
    s_a_ready = 1'b1;
    s_d_opcode = '0; s_d_param = '0; s_d_size = '0; s_d_source = '0;
    s_d_denied = 1'b0; s_d_data = '0; s_d_corrupt = 1'b0; s_d_valid = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_get();
    test_rr_alternate();
    test_burst_lock();
    test_backpressure();
    test_beat_rules();
    test_d_routing();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/tilelink_n_to_1_arbiter.md
Name: tilelink_n_to_1_arbiter

Overview:
Merges N TileLink-UL/UH masters onto one slave port. This is the many-masters-to-one-slave counterpart of the 1-to-N address-decoding crossbar.
- A channel: round-robin arbitration with burst locking, followed by one registered output slice.
- A source tagging: the winning master index is prepended to a_source.
- D channel: responses are routed combinationally back to the owning master by stripping that tag.

Parameters:
N, 2, number of masters (≥2)
TL_DW, 32, data width in bits (power of two, ≥32)
TL_AW, 32, address width
TL_RS, 4, master source-ID width
TL_SZ, 4, size field width
IW, $clog2(N), derived; index tag width, not overridable

Ports:
tilelink_clock_i  in  1  clock
tilelink_reset_i  in  1  asynchronous active-high reset
master_a_opcode  in  3*N  per-master A opcode
master_a_param  in  3*N  A param
master_a_size  in  TL_SZ*N  log2 bytes
master_a_source  in  TL_RS*N  source ID
master_a_address  in  TL_AW*N  address
master_a_mask  in  (TL_DW/8)*N  byte mask
master_a_data  in  TL_DW*N  write data
master_a_corrupt  in  N  corrupt
master_a_valid  in  N  valid
master_a_ready  out  N  ready
master_d_opcode  out  3*N  D opcode
master_d_param  out  2*N  D param
master_d_size  out  TL_SZ*N  size
master_d_source  out  TL_RS*N  source (tag stripped)
master_d_denied  out  N  denied
master_d_data  out  TL_DW*N  read data
master_d_corrupt  out  N  corrupt
master_d_valid  out  N  valid
master_d_ready  in  N  ready
slave_a_opcode/param/size/address/mask/data/corrupt  out  3/3/TL_SZ/TL_AW/TL_DW/8/TL_DW/1  registered A fields
slave_a_source  out  TL_RS+IW  {master index, master source}
slave_a_valid  out  1  registered valid
slave_a_ready  in  1  slave ready
slave_d_opcode/param/size/denied/data/corrupt  in  3/2/TL_SZ/1/TL_DW/1  D fields
slave_d_source  in  TL_RS+IW  tagged source
slave_d_valid  in  1  valid
slave_d_ready  out  1  ready

Behaviour:
- Reset (async assert, released on clock): slave_a_valid=0, lock=0, locked index=0, rr pointer=0, beat counter=0. Registered A payload is don't-care. Reset mid-burst abandons the burst; no residual lock remains.
- Slot free: `advance = !slave_a_valid | slave_a_ready`.
- Grant, unlocked: first valid master scanning rr pointer, pointer+1, … modulo N. Grant is combinational each cycle.
- Grant, locked: only the locked index may be granted.
- A handshake:
  - master_a_ready[i] = grant[i] & advance; at most one bit is set.
  - Accepted beat loads the output slice next cycle, slave_a_valid=1. A-channel latency is 1 cycle.
  - No accept and slave_a_ready=1: slave_a_valid falls to 0.
  - slave_a_valid=1 and slave_a_ready=0: all output fields hold stable.
- Beats per message: let B = log2(TL_DW/8).
  - Multi-beat when opcode ∈ {0,1,2,3} and B < size ≤ 12; beats = 2^(size−B).
  - Otherwise one beat. Get(4) is always one beat; sizes 13–15 are treated as one beat.
- Burst lock:
  - On accepting the first beat of a multi-beat message: lock=1, locked index=winner, counter=beats−1.
  - Each later accepted beat decrements the counter.
  - Accepting the beat with counter==1 clears lock.
  - Other masters are never granted mid-burst.
- RR pointer: updates to winner+1 (mod N) when the last beat of a message is accepted. Single-beat messages count as their own last beat.
- Source tagging: slave_a_source = {winner index (IW bits), master source (TL_RS bits)}.
- D routing (combinational, no state):
  - Index d = slave_d_source[TL_RS+IW−1:TL_RS].
  - master_d_valid[i] = slave_d_valid & (d==i).
  - slave_d_ready = master_d_ready[d].
  - All D payload fields fan out to every master; master_d_source = low TL_RS bits.
- Out-of-range tag d ≥ N (only possible when N is not a power of two): slave_d_ready=1 and the beat is dropped. This cannot occur with a legal slave.
- Multi-beat D (AccessAckData bursts) needs no lock, because every beat carries the same source.

Test Plan:
- Reset, then master0 Get (opcode 4, size 2, source 3, addr 0x100) -> one cycle later slave_a_valid=1, slave_a_source=0x03, master_a_ready[0] was 1 for exactly one cycle.
- Masters 0 and 1 both hold single-beat Puts continuously, slave_a_ready=1 -> slave sees alternating indices 0,1,0,1; rr pointer toggles every cycle.
- Master1 PutFullData size 4 (16 B, 4 beats at TL_DW=32) while master0 also requests -> all 4 beats from master1 are consecutive with slave_a_source[4]=1; master0 is granted only after beat 4.
- slave_a_ready=0 for 3 cycles with slave_a_valid=1 -> output fields stable; master_a_ready all 0; then ready=1 -> next beat loads on the same edge.
- slave_d_valid=1, source=0x15 (tag 1, source 5), master_d_ready[1]=0 -> master_d_valid=2'b10, master_d_source[1]=5, slave_d_ready=0; raise master_d_ready[1] -> slave_d_ready=1.
- Assert reset on beat 2 of a 4-beat burst -> slave_a_valid=0 immediately; after release, master0's single-beat request is granted on the first cycle.
